// File: rtl/uart_link_pkg.sv
// rtl/uart_link_pkg.sv - shared constants and types for the UART link mux
package uart_link_pkg;

  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_IRQ_EN = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_TX_OVR   = 6;
  localparam int ST_RX_OVR   = 7;

  localparam int IRQ_RX_NE    = 0;
  localparam int IRQ_TX_EMPTY = 1;
  localparam int IRQ_OVR      = 2;

  localparam int TAG_BIT = 7;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_START     = 2'd1,
    ARB_WAIT_LOW  = 2'd2,
    ARB_WAIT_HIGH = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with occupancy count
// A pop on an empty FIFO is ignored; a push while full succeeds only if a pop frees the slot.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [3:0]       count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == 4'd0);
  assign full    = (count == 4'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      if (do_push && !do_pop)      count <= count + 4'd1;
      else if (do_pop && !do_push) count <= count - 4'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/uart_link_mux.sv
// rtl/uart_link_mux.sv - splits UART traffic between the protocol engine and a CPU bus port
// Tagged bytes (bit 7 set) belong to the protocol engine; untagged bytes go through the bus FIFOs.
module uart_link_mux
  import uart_link_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int TX_DEPTH = 4,
  parameter int FAIR     = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_rx_dat,
  input  logic       i_rx_pulse,
  output logic [7:0] o_tx_dat,
  output logic       o_tx_start,
  input  logic       i_tx_ready,
  output logic [7:0] o_prot_rx_dat,
  output logic       o_prot_rx_pulse,
  input  logic [7:0] i_prot_tx_dat,
  input  logic       i_prot_tx_pulse,
  output logic       o_prot_tx_ready,
  input  logic [7:0] i_slave_dat,
  output logic [7:0] o_slave_dat,
  input  logic [1:0] i_slave_addr,
  input  logic       i_slave_we,
  input  logic       i_slave_cs,
  output logic       o_slave_ack,
  output logic       o_int
);

  logic       rx_push, rx_pop, rx_empty, rx_full;
  logic [7:0] rx_head;
  logic [3:0] rx_count;
  logic       tx_push, tx_pop, tx_empty, tx_full;
  logic [6:0] tx_head;
  logic [3:0] tx_count;

  logic       rx_ovr, tx_ovr;
  logic [2:0] irq_en;
  logic [2:0] irq_src;
  logic [7:0] status;
  logic [7:0] rd_mux;

  logic       prot_full;
  logic [6:0] prot_buf;
  arb_state_t state;
  logic       prio_prot;
  logic       arb_go, pick_prot;

  logic       accept, rd_data, wr_data, wr_status, wr_irq;
  logic       unused_prot_tag;

  assign unused_prot_tag = i_prot_tx_dat[TAG_BIT];

  // Ack doubles as a busy flag, so a held chip select is accepted every other cycle.
  assign accept    = i_slave_cs & ~o_slave_ack;
  assign rd_data   = accept & ~i_slave_we & (i_slave_addr == REG_DATA);
  assign wr_data   = accept &  i_slave_we & (i_slave_addr == REG_DATA);
  assign wr_status = accept &  i_slave_we & (i_slave_addr == REG_STATUS);
  assign wr_irq    = accept &  i_slave_we & (i_slave_addr == REG_IRQ_EN);

  assign rx_push = i_rx_pulse & ~i_rx_dat[TAG_BIT];
  assign rx_pop  = rd_data & ~rx_empty;
  assign tx_push = wr_data;

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .push     (rx_push),
    .push_dat (i_rx_dat),
    .pop      (rx_pop),
    .head     (rx_head),
    .empty    (rx_empty),
    .full     (rx_full),
    .count    (rx_count)
  );

  sync_fifo #(.WIDTH(7), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .push     (tx_push),
    .push_dat (i_slave_dat[6:0]),
    .pop      (tx_pop),
    .head     (tx_head),
    .empty    (tx_empty),
    .full     (tx_full),
    .count    (tx_count)
  );

  assign o_prot_tx_ready = ~prot_full;

  // prio_prot remembers who should win the next tie; it only matters in fair mode.
  assign pick_prot = prot_full & (tx_empty | ((FAIR != 0) && prio_prot));
  assign arb_go    = (state == ARB_IDLE) & i_tx_ready & (~tx_empty | prot_full);
  assign tx_pop    = arb_go & ~pick_prot;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_prot_rx_pulse <= 1'b0;
      o_prot_rx_dat   <= 8'h00;
    end else begin
      o_prot_rx_pulse <= i_rx_pulse & i_rx_dat[TAG_BIT];
      if (i_rx_pulse && i_rx_dat[TAG_BIT]) o_prot_rx_dat <= {1'b0, i_rx_dat[6:0]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      prot_full <= 1'b0;
      prot_buf  <= 7'h00;
    end else if (arb_go && pick_prot) begin
      prot_full <= 1'b0;
    end else if (i_prot_tx_pulse && !prot_full) begin
      prot_full <= 1'b1;
      prot_buf  <= i_prot_tx_dat[6:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ARB_IDLE;
      o_tx_start <= 1'b0;
      o_tx_dat   <= 8'h00;
      prio_prot  <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (arb_go) begin
            state      <= ARB_START;
            o_tx_start <= 1'b1;
            o_tx_dat   <= pick_prot ? {1'b1, prot_buf} : {1'b0, tx_head};
            prio_prot  <= ~pick_prot;
          end
        end
        ARB_START: begin
          o_tx_start <= 1'b0;
          state      <= ARB_WAIT_LOW;
        end
        ARB_WAIT_LOW:  if (!i_tx_ready) state <= ARB_WAIT_HIGH;
        ARB_WAIT_HIGH: if (i_tx_ready)  state <= ARB_IDLE;
        default:       state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    status              = 8'h00;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_OVR]   = tx_ovr;
    status[ST_RX_OVR]   = rx_ovr;
  end

  always_comb begin
    irq_src               = 3'b000;
    irq_src[IRQ_RX_NE]    = ~rx_empty;
    irq_src[IRQ_TX_EMPTY] = tx_empty;
    irq_src[IRQ_OVR]      = rx_ovr | tx_ovr;
  end

  always_comb begin
    case (i_slave_addr)
      REG_STATUS: rd_mux = status;
      REG_DATA:   rd_mux = rx_empty ? 8'h00 : rx_head;
      REG_IRQ_EN: rd_mux = {5'b00000, irq_en};
      default:    rd_mux = {rx_count, tx_count};
    endcase
  end

  // A fresh overrun in the same cycle as a W1C wins, so no event is lost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_slave_ack <= 1'b0;
      o_slave_dat <= 8'h00;
      irq_en      <= 3'b000;
      rx_ovr      <= 1'b0;
      tx_ovr      <= 1'b0;
      o_int       <= 1'b0;
    end else begin
      o_slave_ack <= accept;
      if (accept && !i_slave_we) o_slave_dat <= rd_mux;
      if (wr_irq) irq_en <= i_slave_dat[2:0];
      if (rx_push && rx_full && !rx_pop)          rx_ovr <= 1'b1;
      else if (wr_status && i_slave_dat[ST_RX_OVR]) rx_ovr <= 1'b0;
      if (tx_push && tx_full && !tx_pop)          tx_ovr <= 1'b1;
      else if (wr_status && i_slave_dat[ST_TX_OVR]) tx_ovr <= 1'b0;
      o_int <= |(irq_en & irq_src);
    end
  end

endmodule
